// File: rtl/mux2x1_stream_arb_pkg.sv
// Shared constants and types for the 2-input stream arbiter.
// Source ids, default width and the output-stage state encoding.
package mux2x1_stream_arb_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux2x1_stream_arb_if.sv
// Valid/ready stream bundle with end-of-packet marker.
// master drives the beat, slave returns ready.
interface mux2x1_stream_arb_if
  import mux2x1_stream_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );

endinterface

// File: rtl/mux2x1_stream_arb_rr_arb2.sv
// Combinational two-way grant logic: lock, then priority, then lone request.
// req[0] is source A, req[1] is source B.
module rr_arb2
  import mux2x1_stream_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       lock,
  input  logic       lock_src,
  output logic       gnt_valid,
  output logic       gnt
);

  logic both;
  logic only_a;
  logic only_b;

  assign both   = ~lock &  req[0] &  req[1];
  assign only_a = ~lock &  req[0] & ~req[1];
  assign only_b = ~lock & ~req[0] &  req[1];

  // A locked packet holds the grant even while its source idles.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = SRC_A;
    unique case (1'b1)
      lock: begin
        gnt       = lock_src;
        gnt_valid = req[lock_src];
      end
      both: begin
        gnt       = prio;
        gnt_valid = 1'b1;
      end
      only_a: begin
        gnt       = SRC_A;
        gnt_valid = 1'b1;
      end
      only_b: begin
        gnt       = SRC_B;
        gnt_valid = 1'b1;
      end
      default: begin
        gnt       = SRC_A;
        gnt_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mux2x1_stream_arb.sv
// Round-robin 2:1 stream arbiter with a one-entry registered output stage.
// Define MUX2X1_PKT_LOCK_EN to hold the grant for a whole packet.
module mux2x1_stream_arb
  import mux2x1_stream_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mux2x1_stream_arb_if.slave   a,
  mux2x1_stream_arb_if.slave   b,
  mux2x1_stream_arb_if.master  y,
  output logic                 y_src,
  output logic                 sel
);

  state_t            state;
  state_t            state_nxt;
  logic              rst_done;
  logic              prio;
  logic              lock;
  logic              lock_src;
  logic              can_accept;
  logic              gnt_valid;
  logic              gnt;
  logic              xfer;
  logic              x_last;
  logic [DATA_W-1:0] x_data;
  logic [DATA_W-1:0] y_data_q;
  logic              y_last_q;

  assign can_accept = rst_done & (~y.valid | y.ready);

  rr_arb2 u_arb (
    .req       ({b.valid, a.valid}),
    .prio      (prio),
    .lock      (lock),
    .lock_src  (lock_src),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign a.ready = can_accept & gnt_valid
                 & (gnt == SRC_A) & a.valid;
  assign b.ready = can_accept & gnt_valid
                 & (gnt == SRC_B) & b.valid;
  assign xfer    = a.ready | b.ready;

  assign x_data = (gnt == SRC_B) ? b.data : a.data;
  assign x_last = (gnt == SRC_B) ? b.last : a.last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: if (xfer) state_nxt = FULL;
      FULL:  if (y.ready && !xfer) state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    y.valid = (state == FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      y_data_q <= '0;
      y_last_q <= 1'b0;
      y_src    <= SRC_A;
      sel      <= SRC_A;
    end else begin
      rst_done <= 1'b1;
      if (xfer) begin
        y_data_q <= x_data;
        y_last_q <= x_last;
        y_src    <= gnt;
        sel      <= gnt;
      end
    end
  end

  assign y.data = y_data_q;
  assign y.last = y_last_q;

`ifdef MUX2X1_PKT_LOCK_EN
  // Rotation only moves on at a packet boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio     <= SRC_A;
      lock     <= 1'b0;
      lock_src <= SRC_A;
    end else if (xfer) begin
      lock     <= ~x_last;
      lock_src <= gnt;
      if (x_last) prio <= ~gnt;
    end
  end
`else
  assign lock     = 1'b0;
  assign lock_src = SRC_A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= SRC_A;
    end else if (xfer) begin
      prio <= ~gnt;
    end
  end
`endif

endmodule
